// File: rtl/interrupt_sequencer.sv
// -----------------------------------------------------------------------------
// interrupt_sequencer
//
// Purpose:
//   Sequences processor entry into reset, NMI and IRQ service. External pins
//   are synchronized, NMI is edge-latched, IRQ is level-sampled, and a small
//   FSM (HOLD / IDLE / SEQ) walks a 7-step entry sequence (steps 0..6). The
//   decode and bus logic use the outputs to force a BRK opcode, hold rwb high
//   during reset stack cycles, and fetch the vector at steps 5 and 6.
//   An NMI arriving early enough in an IRQ sequence redirects it to the NMI
//   vector.
//
// Ports:
//   phi2           in   1   clock; all state updates on the rising edge
//   rst            in   1   synchronous active-high reset
//   resb           in   1   external reset pin, active-low, asynchronous
//   nmib           in   1   external NMI pin, active-low, asynchronous
//   irqb           in   1   external IRQ pin, active-low, asynchronous
//   rdy            in   1   1 = advance, 0 = stall
//   sync           in   1   opcode-fetch cycle indicator from decode
//   i_flag         in   1   processor status I bit (1 masks IRQ)
//   seq_active     out  1   entry sequence in progress
//   int_type       out  2   00 none, 01 IRQ, 10 NMI, 11 RESET
//   seq_step       out  3   sequence step, 0..6
//   force_brk      out  1   decode substitutes opcode 00
//   suppress_write out  1   decode holds rwb high (reset stack cycles)
//   vpb            out  1   active-low vector-pull indicator
//   vector_addr    out  16  vector address for steps 5 and 6, else 0000
//   b_flag_out     out  1   B bit for the pushed status byte
//
// All outputs come straight from flops; nothing on a pin reaches an output
// without passing through registered state first.
// -----------------------------------------------------------------------------
module interrupt_sequencer (
    input  logic        phi2,
    input  logic        rst,
    input  logic        resb,
    input  logic        nmib,
    input  logic        irqb,
    input  logic        rdy,
    input  logic        sync,
    input  logic        i_flag,
    output logic        seq_active,
    output logic [1:0]  int_type,
    output logic [2:0]  seq_step,
    output logic        force_brk,
    output logic        suppress_write,
    output logic        vpb,
    output logic [15:0] vector_addr,
    output logic        b_flag_out
);

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_IDLE = 2'd1,
        ST_SEQ  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        INT_NONE  = 2'b00,
        INT_IRQ   = 2'b01,
        INT_NMI   = 2'b10,
        INT_RESET = 2'b11
    } int_e;

    localparam logic [2:0] LAST_STEP   = 3'd6;
    localparam logic [2:0] HIJACK_STEP = 3'd4;   // last step where an NMI may redirect an IRQ

    // ------------------------------------------------------------------
    // Synchronizers and NMI edge detector
    // ------------------------------------------------------------------
    logic res_meta_q, res_sync_q;
    logic nmi_meta_q, nmi_sync_q, nmi_prev_q;
    logic irq_meta_q, irq_sync_q;
    logic nmi_latch_q, nmi_latch_d;

    // ------------------------------------------------------------------
    // Sequencer state and registered outputs
    // ------------------------------------------------------------------
    state_e     state_q, state_d;
    int_e       int_type_q, int_type_d;
    logic [2:0] seq_step_q, seq_step_d;

    logic        seq_active_q, seq_active_d;
    logic        force_brk_q, force_brk_d;
    logic        suppress_write_q, suppress_write_d;
    logic        vpb_q, vpb_d;
    logic [15:0] vector_addr_q, vector_addr_d;
    logic        b_flag_q, b_flag_d;

    logic        nmi_fall;
    logic        irq_pending;
    logic        vec_cycle_d;
    logic [15:0] vec_base_d;

    // Falling edge of the synchronized NMI; a held-low pin gives one pulse.
    assign nmi_fall    = nmi_prev_q & ~nmi_sync_q;
    // IRQ is a sampled level, masked by the I bit; it is never latched.
    assign irq_pending = ~irq_sync_q & ~i_flag;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written in this block takes a default first,
        // so no branch leaves it unassigned and no latch is inferred.
        state_d     = state_q;
        int_type_d  = int_type_q;
        seq_step_d  = seq_step_q;
        nmi_latch_d = nmi_latch_q;

        if (!res_sync_q) begin
            // Reset pin low aborts whatever is running, including a sequence.
            state_d    = ST_HOLD;
            int_type_d = INT_NONE;
            seq_step_d = 3'd0;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    state_d    = ST_SEQ;
                    int_type_d = INT_RESET;
                    seq_step_d = 3'd0;
                end

                ST_IDLE: begin
                    if (sync && rdy) begin
                        // NMI outranks IRQ; a losing IRQ is simply seen again
                        // at the next opcode fetch because it is a level.
                        if (nmi_latch_q) begin
                            state_d    = ST_SEQ;
                            int_type_d = INT_NMI;
                            seq_step_d = 3'd0;
                        end else if (irq_pending) begin
                            state_d    = ST_SEQ;
                            int_type_d = INT_IRQ;
                            seq_step_d = 3'd0;
                        end
                    end
                end

                ST_SEQ: begin
                    // Vector hijack: an NMI seen before the vector fetch turns
                    // the IRQ into an NMI; later ones wait for the next entry.
                    if (int_type_q == INT_IRQ && nmi_latch_q && seq_step_q <= HIJACK_STEP) begin
                        int_type_d = INT_NMI;
                    end
                    if (rdy) begin
                        if (seq_step_q == LAST_STEP) begin
                            state_d    = ST_IDLE;
                            int_type_d = INT_NONE;
                            seq_step_d = 3'd0;
                            if (int_type_q == INT_NMI) begin
                                nmi_latch_d = 1'b0;
                            end
                        end else begin
                            seq_step_d = seq_step_q + 3'd1;
                        end
                    end
                end

                default: begin
                    state_d    = ST_HOLD;
                    int_type_d = INT_NONE;
                    seq_step_d = 3'd0;
                end
            endcase
        end

        // A fresh edge wins over a same-cycle clear so it is never lost.
        if (nmi_fall) begin
            nmi_latch_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Output decode from next state, registered below
    // ------------------------------------------------------------------
    always_comb begin
        vec_base_d = 16'h0000;
        case (int_type_d)
            INT_RESET: vec_base_d = 16'hFFFC;
            INT_NMI:   vec_base_d = 16'hFFFA;
            INT_IRQ:   vec_base_d = 16'hFFFE;
            default:   vec_base_d = 16'h0000;
        endcase

        vec_cycle_d      = (state_d == ST_SEQ) && (seq_step_d >= 3'd5);
        seq_active_d     = (state_d == ST_SEQ);
        force_brk_d      = (state_d == ST_SEQ) && (seq_step_d == 3'd0);
        suppress_write_d = (state_d == ST_SEQ) && (int_type_d == INT_RESET)
                           && (seq_step_d >= 3'd2) && (seq_step_d <= 3'd4);
        vpb_d            = ~vec_cycle_d;
        b_flag_d         = (state_d != ST_SEQ);
        // Vector bases are even: step 5 fetches the low byte, step 6 the high.
        vector_addr_d    = vec_cycle_d
                           ? (vec_base_d | {15'd0, (seq_step_d == LAST_STEP)})
                           : 16'h0000;
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge phi2) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples pre-edge values regardless of statement order.
        if (rst) begin
            res_meta_q       <= 1'b1;
            res_sync_q       <= 1'b1;
            nmi_meta_q       <= 1'b1;
            nmi_sync_q       <= 1'b1;
            nmi_prev_q       <= 1'b1;
            irq_meta_q       <= 1'b1;
            irq_sync_q       <= 1'b1;
            nmi_latch_q      <= 1'b0;
            state_q          <= ST_HOLD;
            int_type_q       <= INT_NONE;
            seq_step_q       <= 3'd0;
            seq_active_q     <= 1'b0;
            force_brk_q      <= 1'b0;
            suppress_write_q <= 1'b0;
            vpb_q            <= 1'b1;
            vector_addr_q    <= 16'h0000;
            b_flag_q         <= 1'b1;
        end else begin
            res_meta_q       <= resb;
            res_sync_q       <= res_meta_q;
            nmi_meta_q       <= nmib;
            nmi_sync_q       <= nmi_meta_q;
            nmi_prev_q       <= nmi_sync_q;
            irq_meta_q       <= irqb;
            irq_sync_q       <= irq_meta_q;
            nmi_latch_q      <= nmi_latch_d;
            state_q          <= state_d;
            int_type_q       <= int_type_d;
            seq_step_q       <= seq_step_d;
            seq_active_q     <= seq_active_d;
            force_brk_q      <= force_brk_d;
            suppress_write_q <= suppress_write_d;
            vpb_q            <= vpb_d;
            vector_addr_q    <= vector_addr_d;
            b_flag_q         <= b_flag_d;
        end
    end

    assign seq_active     = seq_active_q;
    assign int_type       = int_type_q;
    assign seq_step       = seq_step_q;
    assign force_brk      = force_brk_q;
    assign suppress_write = suppress_write_q;
    assign vpb            = vpb_q;
    assign vector_addr    = vector_addr_q;
    assign b_flag_out     = b_flag_q;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// -----------------------------------------------------------------------------
// tb_interrupt_sequencer
//
// Drives directed scenarios (reset entry, IRQ, masked IRQ, NMI edge, hijack
// early and late, stall, resb abort, rst abort) followed by random pin
// activity. A behavioural model tracks pin history, the NMI latch and the
// current sequence (kind + step) and pushes the expected output set for each
// clock into a queue; an independent monitor pops and compares on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_interrupt_sequencer;

    logic        phi2;
    logic        rst, resb, nmib, irqb, rdy, sync, i_flag;
    logic        seq_active;
    logic [1:0]  int_type;
    logic [2:0]  seq_step;
    logic        force_brk, suppress_write, vpb, b_flag_out;
    logic [15:0] vector_addr;

    interrupt_sequencer dut (
        .phi2          (phi2),
        .rst           (rst),
        .resb          (resb),
        .nmib          (nmib),
        .irqb          (irqb),
        .rdy           (rdy),
        .sync          (sync),
        .i_flag        (i_flag),
        .seq_active    (seq_active),
        .int_type      (int_type),
        .seq_step      (seq_step),
        .force_brk     (force_brk),
        .suppress_write(suppress_write),
        .vpb           (vpb),
        .vector_addr   (vector_addr),
        .b_flag_out    (b_flag_out)
    );

    initial phi2 = 1'b0;
    always #5 phi2 = ~phi2;

    typedef struct packed {
        logic        active;
        logic [1:0]  kind;
        logic [2:0]  step;
        logic        brk;
        logic        nowr;
        logic        vpb;
        logic [15:0] vec;
        logic        bflag;
    } obs_t;

    obs_t scb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    // Stimulus requested by the scenario code; copied to the pins mid-cycle.
    logic s_rst, s_resb, s_nmib, s_irqb, s_rdy, s_sync, s_iflag;

    // ------------------------------------------------------------------
    // Reference model: sequence kind (0 none, 1 IRQ, 2 NMI, 3 RESET),
    // step number, NMI latch, and the last three sampled values of each pin.
    // ------------------------------------------------------------------
    localparam int P_HOLD = 0, P_IDLE = 1, P_SEQ = 2;
    int m_phase = P_HOLD;
    int m_kind  = 0;
    int m_step  = 0;
    bit m_latch = 1'b0;
    bit res_h [3];
    bit nmi_h [3];
    bit irq_h [3];
    logic [15:0] vec_tab [4];

    initial begin
        vec_tab[0] = 16'h0000;
        vec_tab[1] = 16'hFFFE;
        vec_tab[2] = 16'hFFFA;
        vec_tab[3] = 16'hFFFC;
    end

    task automatic start_seq(input int kind);
        m_phase = P_SEQ;
        m_kind  = kind;
        m_step  = 0;
    endtask

    task automatic model_edge();
        bit fall;
        if (s_rst) begin
            for (int i = 0; i < 3; i++) begin
                res_h[i] = 1'b1;
                nmi_h[i] = 1'b1;
                irq_h[i] = 1'b1;
            end
            m_latch = 1'b0;
            m_phase = P_HOLD;
            m_kind  = 0;
            m_step  = 0;
        end else begin
            // Pins seen by the logic are those sampled two edges ago.
            fall = nmi_h[2] && !nmi_h[1];
            if (!res_h[1]) begin
                m_phase = P_HOLD;
                m_kind  = 0;
                m_step  = 0;
            end else if (m_phase == P_HOLD) begin
                start_seq(3);
            end else if (m_phase == P_IDLE) begin
                if (s_sync && s_rdy) begin
                    if (m_latch)                     start_seq(2);
                    else if (!irq_h[1] && !s_iflag)  start_seq(1);
                end
            end else begin
                if (m_kind == 1 && m_latch && m_step <= 4) m_kind = 2;
                if (s_rdy) begin
                    if (m_step == 6) begin
                        if (m_kind == 2) m_latch = 1'b0;
                        m_phase = P_IDLE;
                        m_kind  = 0;
                        m_step  = 0;
                    end else begin
                        m_step = m_step + 1;
                    end
                end
            end
            if (fall) m_latch = 1'b1;
            res_h[2] = res_h[1]; res_h[1] = res_h[0]; res_h[0] = s_resb;
            nmi_h[2] = nmi_h[1]; nmi_h[1] = nmi_h[0]; nmi_h[0] = s_nmib;
            irq_h[2] = irq_h[1]; irq_h[1] = irq_h[0]; irq_h[0] = s_irqb;
        end
    endtask

    function automatic obs_t model_out();
        obs_t e;
        bit   in_seq;
        bit   vec_cyc;
        in_seq  = (m_phase == P_SEQ);
        vec_cyc = in_seq && (m_step >= 5);
        e.active = in_seq;
        e.kind   = in_seq ? 2'(m_kind) : 2'b00;
        e.step   = in_seq ? 3'(m_step) : 3'd0;
        e.brk    = in_seq && (m_step == 0);
        e.nowr   = in_seq && (m_kind == 3) && (m_step >= 2) && (m_step <= 4);
        e.vpb    = !vec_cyc;
        e.vec    = vec_cyc ? (vec_tab[m_kind] + 16'(m_step - 5)) : 16'h0000;
        e.bflag  = !in_seq;
        return e;
    endfunction

    // One clock: apply stimulus after the falling edge, advance the model,
    // and queue what the DUT must show after the coming rising edge.
    task automatic tick();
        obs_t e;
        @(negedge phi2);
        #1;
        rst    = s_rst;
        resb   = s_resb;
        nmib   = s_nmib;
        irqb   = s_irqb;
        rdy    = s_rdy;
        sync   = s_sync;
        i_flag = s_iflag;
        model_edge();
        e = model_out();
        @(posedge phi2);
        scb.push_back(e);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_sync();
        s_sync = 1'b1;
        tick();
        s_sync = 1'b0;
    endtask

    task automatic run_until_step(input int step, input int budget);
        int n;
        n = 0;
        while (!(m_phase == P_SEQ && m_step == step) && n < budget) begin
            tick();
            n++;
        end
        n_checks++;
        if (!(m_phase == P_SEQ && m_step == step)) begin
            n_fail++;
            $display("FAIL wait_step: reached phase %0d step %0d, wanted step %0d", m_phase, m_step, step);
        end
    endtask

    task automatic raise_irq();
        s_irqb  = 1'b0;
        s_iflag = 1'b0;
        ticks(3);
        pulse_sync();
        s_irqb  = 1'b1;
    endtask

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    initial begin
        obs_t e;
        obs_t a;
        forever begin
            @(negedge phi2);
            if (scb.size() != 0) begin
                e = scb.pop_front();
                a.active = seq_active;
                a.kind   = int_type;
                a.step   = seq_step;
                a.brk    = force_brk;
                a.nowr   = suppress_write;
                a.vpb    = vpb;
                a.vec    = vector_addr;
                a.bflag  = b_flag_out;
                cyc++;
                n_checks++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL outputs cycle %0d: got act=%b type=%b step=%0d brk=%b nowr=%b vpb=%b vec=%h b=%b, expected act=%b type=%b step=%0d brk=%b nowr=%b vpb=%b vec=%h b=%b",
                             cyc, a.active, a.kind, a.step, a.brk, a.nowr, a.vpb, a.vec, a.bflag,
                             e.active, e.kind, e.step, e.brk, e.nowr, e.vpb, e.vec, e.bflag);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        s_rst = 1'b1; s_resb = 1'b1; s_nmib = 1'b1; s_irqb = 1'b1;
        s_rdy = 1'b1; s_sync = 1'b0; s_iflag = 1'b1;
        rst = 1'b1; resb = 1'b1; nmib = 1'b1; irqb = 1'b1;
        rdy = 1'b1; sync = 1'b0; i_flag = 1'b1;

        // Reset: three cycles of rst, then the reset entry sequence.
        ticks(3);
        s_rst = 1'b0;
        ticks(12);

        // IRQ taken, then the same level masked by I.
        raise_irq();
        ticks(10);
        s_iflag = 1'b1;
        s_irqb  = 1'b0;
        ticks(3);
        pulse_sync();
        ticks(4);
        s_irqb = 1'b1;
        ticks(3);

        // NMI held low for 20 cycles across two opcode fetches: one entry.
        s_nmib = 1'b0;
        ticks(5);
        pulse_sync();
        ticks(9);
        pulse_sync();
        ticks(4);
        s_nmib = 1'b1;
        ticks(4);

        // NMI edge landing at step 3 of an IRQ: hijacked, no re-entry.
        raise_irq();
        run_until_step(0, 4);
        s_nmib = 1'b0;
        ticks(10);
        pulse_sync();
        ticks(3);
        s_nmib = 1'b1;
        ticks(4);

        // NMI edge landing at step 5: IRQ vectors, NMI on the next fetch.
        raise_irq();
        run_until_step(2, 6);
        s_nmib = 1'b0;
        ticks(8);
        pulse_sync();
        ticks(9);
        s_nmib = 1'b1;
        ticks(4);

        // Stall for four cycles at step 4.
        raise_irq();
        run_until_step(4, 10);
        s_rdy = 1'b0;
        ticks(4);
        s_rdy = 1'b1;
        ticks(6);

        // resb asserted at step 3 aborts into a fresh reset sequence.
        raise_irq();
        run_until_step(3, 10);
        s_resb = 1'b0;
        ticks(4);
        s_resb = 1'b1;
        ticks(12);

        // rst asserted mid-sequence.
        raise_irq();
        run_until_step(2, 10);
        s_rst = 1'b1;
        tick();
        s_rst = 1'b0;
        ticks(12);

        // Random pin activity.
        for (int c = 0; c < 3000; c++) begin
            s_sync = ($urandom_range(3) == 0);
            s_rdy  = ($urandom_range(7) != 0);
            if ($urandom_range(19) == 0) s_iflag = ~s_iflag;
            if ($urandom_range(14) == 0) s_irqb  = ~s_irqb;
            if ($urandom_range(24) == 0) s_nmib  = ~s_nmib;
            s_resb = ($urandom_range(249) != 0);
            s_rst  = ($urandom_range(599) == 0);
            tick();
        end

        s_rst = 1'b0; s_resb = 1'b1; s_sync = 1'b0; s_rdy = 1'b1;
        ticks(4);
        @(negedge phi2);
        #1;
        n_checks++;
        if (scb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected entries left unchecked, wanted 0", scb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/interrupt_sequencer.md
INTERRUPT_SEQUENCER -- requirements
Module: interrupt_sequencer

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: phi2 is the single clock; rst is synchronous and active-high.
REQ-002 SHALL have these ports (name  direction  width  meaning):
- phi2  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- resb  in  1  external reset pin, active-low, asynchronous.
- nmib  in  1  external NMI pin, active-low, asynchronous.
- irqb  in  1  external IRQ pin, active-low, asynchronous.
- rdy  in  1  high = advance; low = stall.
- sync  in  1  opcode-fetch cycle indicator from decode.
- i_flag  in  1  processor status I bit.
- seq_active  out  1  interrupt/reset entry sequence in progress.
- int_type  out  2  00 none, 01 IRQ, 10 NMI, 11 RESET.
- seq_step  out  3  sequence step, 0..6.
- force_brk  out  1  decode shall substitute opcode 00.
- suppress_write  out  1  decode shall hold rwb high (reset stack cycles).
- vpb  out  1  active-low vector-pull indicator.
- vector_addr  out  16  vector address on the address bus.
- b_flag_out  out  1  B bit value for the pushed status byte.

Function
REQ-003 SHALL pass resb, nmib and irqb each through a 2-flop synchronizer (flops reset to 1), giving a 2-cycle input latency.
REQ-004 SHALL set nmi_latch on the cycle the synced nmib goes 1->0 (falling edge only).
- A held-low nmib SHALL NOT retrigger.
- nmi_latch SHALL clear only as specified in REQ-010.
REQ-005 SHALL treat IRQ as pending while synced irqb==0 and i_flag==0; the level is sampled, not latched.
REQ-006 SHALL implement an FSM with states HOLD, IDLE and SEQ.
REQ-007 HOLD transitions:
- Entered on rst, or whenever synced resb==0 (from any state, overriding SEQ).
- Exit to SEQ with int_type=11 and seq_step=0 on the first cycle synced resb==1 and rst==0.
REQ-008 IDLE transitions:
- When sync==1 and rdy==1, SHALL enter SEQ at step 0.
- Priority: NMI (nmi_latch) over IRQ; int_type is latched at entry.
- With no request pending, SHALL stay in IDLE.
REQ-009 SEQ stepping:
- seq_step SHALL increment by 1 per cycle with rdy==1 and hold when rdy==0.
- After step 6 completes with rdy==1, SHALL go to IDLE with int_type=00 and seq_step=0.
REQ-010 NMI hijack and latch clearing:
- If nmi_latch is set while int_type==01 and seq_step<=4, int_type SHALL change to 10 (vector hijack).
- nmi_latch SHALL clear when step 6 completes with int_type==10.
- An NMI edge arriving at step >=5 SHALL stay latched for the next sequence.
REQ-011 force_brk SHALL be 1 only in SEQ at step 0.
REQ-012 suppress_write SHALL be 1 only in SEQ with int_type==11 and seq_step in 2..4.
REQ-013 vpb SHALL be 0 only in SEQ at steps 5 and 6; it is 1 otherwise.
REQ-014 vector_addr by int_type:
- 11: FFFC (step 5), FFFD (step 6).
- 10: FFFA / FFFB.
- 01: FFFE / FFFF.
- 0000 outside steps 5 and 6.
REQ-015 b_flag_out SHALL be 0 during SEQ (hardware interrupt) and 1 otherwise.
REQ-016 Simultaneous events:
- resb assertion beats any in-flight SEQ, which is aborted immediately.
- rst beats everything.
- NMI and IRQ pending together at sync: NMI wins and the IRQ is re-evaluated at the next sync.
REQ-017 All outputs SHALL be registered or decoded from registered state only; there are no combinational paths from pins to outputs.

Reset
REQ-018 While rst==1, the block SHALL drive:
- state=HOLD, synchronizer flops=1, nmi_latch=0.
- seq_active=0, int_type=00, seq_step=0.
- force_brk=0, suppress_write=0, vpb=1, vector_addr=0000, b_flag_out=1.
REQ-019 rst==1 mid-SEQ SHALL abort within one cycle; on release, a full reset sequence SHALL run.

Verification
REQ-020 Reset: rst 1 for 3 cycles, then 0 with resb=1 -> HOLD exit after the synchronizer delay; seq_active=1, int_type=11; suppress_write=1 at steps 2-4; vpb=0 with vector_addr FFFC then FFFD; IDLE after 7 rdy cycles.
REQ-021 IRQ: irqb=0, i_flag=0, sync pulse -> int_type=01, force_brk=1 at step 0, vector_addr FFFE/FFFF at steps 5/6, b_flag_out=0; with i_flag=1 -> no sequence.
REQ-022 NMI edge: nmib 1->0 held low for 20 cycles and two sync pulses -> exactly one NMI sequence (FFFA/FFFB); nmi_latch cleared after step 6.
REQ-023 Hijack: NMI edge during IRQ sequence at step 3 -> vector_addr FFFA/FFFB, int_type=10, no NMI re-entry afterwards; the same edge at step 5 -> IRQ vectors used, NMI sequence on the next sync.
REQ-024 Stall and abort: rdy=0 for 4 cycles at step 4 -> seq_step holds at 4, outputs stable; resb=0 at step 3 -> HOLD after sync delay, seq_active=0, fresh reset sequence on release.
